dsc_mul_seq: RTL and testbench

//  Parametrised deterministic stochastic-computing multiplier, single clock domain.
//  Two counter-compare SNGs form unary streams; stream B advances only on stream-A wrap, giving exact clock-division products.
//  A start/done handshake, operand latching, a stall input and a result register are added.

---
 rtl/dsc_mul_seq_if.sv | 19 +
 rtl/dsc_mul_seq.sv | 119 +++++++++++
 tb/tb_dsc_mul_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dsc_mul_seq_if.sv
// Bus interface for dsc_mul_seq: handshake, operands and result.
//   start, en, a, b   : driven by the requester (master)
//   busy, done, z     : driven by the multiplier (slave)
//   sn_y              : product stream bit, debug and chaining tap
interface dsc_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic               en;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH:0]   z;
    logic               sn_y;

    modport master (output start, en, a, b, input busy, done, z, sn_y);
    modport slave  (input start, en, a, b, output busy, done, z, sn_y);
endinterface

// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: deterministic stochastic-computing multiplier.
// Two counter-compare number generators produce unary streams. Stream B
// advances only when stream A wraps, so every pair (ca, cb) is visited once
// per run. Counting product bits over 2^(2*WIDTH) beats therefore gives the
// exact product.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous reset, active-high
//   bus   : dsc_mul_seq_if.slave
//           start/a/b : request and operands, latched when accepted in IDLE/DONE
//           en        : run enable, 0 stalls counters and accumulator
//           busy      : high in RUN
//           done      : one-cycle pulse, z valid from this cycle
//           z         : product count, held until the next accepted start
//           sn_y      : current product stream bit, 0 outside RUN
//
// Configuration macro: DSC_BIPOLAR_EN
//   When defined, the product bit is XNOR (bipolar multiply), giving
//   z = a*b + (2^N-a)*(2^N-b). Otherwise it is AND (unipolar), giving z = a*b.
module dsc_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    dsc_mul_seq_if.slave  bus
);

    localparam logic [WIDTH-1:0] CMAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   ca_q, ca_d, cb_q, cb_d;
    logic [2*WIDTH:0]   acc_q, acc_d, z_q, z_d;

    logic sa, sb, prod, run, beat, last, accept;

    // Stream generation and control qualifiers.
    always_comb begin
        sa     = (a_q > ca_q);
        sb     = (b_q > cb_q);
`ifdef DSC_BIPOLAR_EN
        prod   = ~(sa ^ sb);
`else
        prod   = sa & sb;
`endif
        run    = (state_q == S_RUN);
        beat   = run & bus.en;
        last   = (ca_q == CMAX) && (cb_q == CMAX);
        // Start is only honoured outside RUN; a request in RUN is dropped.
        accept = bus.start && (state_q != S_RUN);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        acc_d   = acc_q;
        z_d     = z_q;

        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (bus.en && last) state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            a_d   = bus.a;
            b_d   = bus.b;
            ca_d  = '0;
            cb_d  = '0;
            acc_d = '0;
            z_d   = '0;
        end else if (beat) begin
            acc_d = acc_q + {{(2*WIDTH){1'b0}}, prod};
            ca_d  = ca_q + 1'b1;
            if (ca_q == CMAX) cb_d = cb_q + 1'b1;
            // The final bit is folded straight into the result so z is
            // valid in the same cycle that done rises.
            if (last) z_d = acc_q + {{(2*WIDTH){1'b0}}, prod};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            acc_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
        end
    end

    assign bus.busy = run;
    assign bus.done = (state_q == S_DONE);
    assign bus.z    = z_q;
    assign bus.sn_y = run & prod;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed bench for dsc_mul_seq: a WIDTH=4 instance for functional,
// chaining, stall and reset cases, plus a WIDTH=8 instance for one full run.
module tb_dsc_mul_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dsc_mul_seq_if #(.WIDTH(4)) if4 ();
    dsc_mul_seq_if #(.WIDTH(8)) if8 ();

    dsc_mul_seq #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    dsc_mul_seq #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int model(input int av, input int bv, input int n);
`ifdef DSC_BIPOLAR_EN
        return av * bv + ((1 << n) - av) * ((1 << n) - bv);
`else
        return av * bv;
`endif
    endfunction

    function automatic int first_bit(input int av, input int bv);
`ifdef DSC_BIPOLAR_EN
        return ((av > 0) == (bv > 0)) ? 1 : 0;
`else
        return ((av > 0) && (bv > 0)) ? 1 : 0;
`endif
    endfunction

    // One WIDTH=4 run. Called at #1 after an edge with the DUT in IDLE or
    // DONE, so back-to-back calls exercise start-in-DONE chaining.
    task automatic run4(input int av, input int bv, input int st_at,
                        input int st_len, input bit poke);
        int cnt;
        bit seen;
        if4.a     = 4'(av);
        if4.b     = 4'(bv);
        if4.en    = 1'b1;
        if4.start = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        // Operand changes during RUN must not affect the result.
        if4.a = 4'(av + 3);
        if4.b = 4'(bv + 7);
        chk($sformatf("z_clr_%0d_%0d", av, bv), int'(if4.z), 0);
        chk($sformatf("busy_%0d_%0d", av, bv), int'(if4.busy), 1);
        chk($sformatf("sn0_%0d_%0d", av, bv), int'(if4.sn_y), first_bit(av, bv));
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 2000) begin
            if4.en    = !(cnt >= st_at && cnt < st_at + st_len);
            if4.start = poke && (cnt == 50);
            @(posedge clk); #1;
            cnt++;
            seen = if4.done;
        end
        if4.en    = 1'b1;
        if4.start = 1'b0;
        chk($sformatf("lat_%0d_%0d", av, bv), cnt, 256 + st_len);
        chk($sformatf("z_%0d_%0d", av, bv), int'(if4.z), model(av, bv, 4));
    endtask

    int va[13] = '{0, 15, 1, 15, 1, 9, 7, 8, 3, 0, 12, 2, 5};
    int vb[13] = '{0, 15, 1, 1, 15, 5, 11, 8, 0, 12, 13, 14, 10};

    initial begin
        int cnt;
        int pulses;
        int zsave;
        bit seen;

        if4.start = 1'b0; if4.en = 1'b1; if4.a = '0; if4.b = '0;
        if8.start = 1'b0; if8.en = 1'b1; if8.a = '0; if8.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(if4.busy), 0);
        chk("rst_done", int'(if4.done), 0);
        chk("rst_z",    int'(if4.z),    0);
        chk("rst_sny",  int'(if4.sn_y), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Chained vectors; entry 6 also pulses start mid-run.
        for (int i = 0; i < 13; i++) run4(va[i], vb[i], 1000, 0, (i == 6));

        zsave = int'(if4.z);
        @(posedge clk); #1;
        chk("done_pulse", int'(if4.done), 0);
        chk("idle_busy",  int'(if4.busy), 0);
        chk("z_hold",     int'(if4.z),    zsave);
        chk("idle_sny",   int'(if4.sn_y), 0);
        repeat (3) @(posedge clk);
        #1;

        // Stall of 10 cycles mid-run.
        run4(9, 5, 100, 10, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-run aborts without a done pulse.
        if4.a = 4'd9; if4.b = 4'd5; if4.start = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mrst_busy", int'(if4.busy), 0);
        chk("mrst_done", int'(if4.done), 0);
        chk("mrst_z",    int'(if4.z),    0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (if4.done) pulses++;
        end
        chk("mrst_nodone", pulses, 0);

        // Full WIDTH=8 run.
        if8.a = 8'd200; if8.b = 8'd100; if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 70000) begin
            @(posedge clk); #1;
            cnt++;
            seen = if8.done;
        end
        chk("w8_lat", cnt, 65536);
        chk("w8_z",   int'(if8.z), model(200, 100, 8));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
